ipsl_pcie_ext_rcvh_fifo_ctrl: RTL and testbench

- FIFO controller for the PCIe receive-header RAM (144-bit x 512 simple dual-port, registered output, 2-cycle read latency).
- Accepts received TLP headers from the RX TLP parser with a valid/ready handshake and writes them into the RAM.
- Prefetches headers from the RAM into a small skid buffer and presents them to the application-side header consumer with valid/ready.
- Tracks occupancy so the header credit logic can see how many entries are held.

---
 rtl/ipsl_pcie_ext_rcvh_fifo_ctrl.sv | 151 +++++++++++++++
 tb/tb_ipsl_pcie_ext_rcvh_fifo_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_ext_rcvh_fifo_ctrl.sv
// Receive-header FIFO controller. Writes TLP headers from the RX parser into an
// external 144x512 simple dual-port RAM (2-cycle registered read). Prefetches
// them into a small skid buffer that feeds the application-side consumer.
// Optional build macro IPSL_PCIE_RCVH_OVFL_CNT_EN adds the ovfl_cnt stall counter.
module ipsl_pcie_ext_rcvh_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 144,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hdr_wr_valid,
    input  logic [DATA_WIDTH-1:0]   hdr_wr_data,
    output logic                    hdr_wr_ready,
    output logic                    hdr_rd_valid,
    output logic [DATA_WIDTH-1:0]   hdr_rd_data,
    input  logic                    hdr_rd_ready,
    output logic                    ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data,
`ifdef IPSL_PCIE_RCVH_OVFL_CNT_EN
    output logic [15:0]             ovfl_cnt,
`endif
    output logic [ADDR_WIDTH+1:0]   hdr_count
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W   = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 2;
    localparam int unsigned SKID_AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned SKID_CW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned LAT_CW  = $clog2(RD_LAT + 1);

    // Ring pointers with an extra wrap bit
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic [PTR_W-1:0]      ram_used;
    logic [PTR_W-1:0]      ram_used_nxt;

    // Read latency tracking
    logic [RD_LAT-1:0]     rd_pipe;
    logic [RD_LAT-1:0]     rd_pipe_nxt;
    logic [LAT_CW-1:0]     inflight;
    logic [LAT_CW-1:0]     inflight_nxt;

    // Skid buffer
    logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
    logic [SKID_AW-1:0]    skid_wr;
    logic [SKID_AW-1:0]    skid_rd;
    logic [SKID_CW-1:0]    skid_cnt;
    logic [SKID_CW-1:0]    skid_cnt_nxt;

    logic                  wr_accept;
    logic                  rd_issue;
    logic                  pipe_out;
    logic                  skid_pop;
    logic [CNT_W-1:0]      pipe_occ;
    logic [CNT_W-1:0]      count_nxt;

    // Advance a skid buffer index with wrap at SKID_DEPTH
    function automatic logic [SKID_AW-1:0] skid_inc(input logic [SKID_AW-1:0] p);
        return (p == SKID_AW'(SKID_DEPTH - 1)) ? '0 : p + SKID_AW'(1);
    endfunction

    // Handshakes, read issue decision and next-state occupancy
    always_comb begin
        wr_accept    = hdr_wr_valid && hdr_wr_ready;
        ram_used     = wr_ptr - rd_ptr;
        pipe_occ     = CNT_W'(inflight) + CNT_W'(skid_cnt);
        rd_issue     = (ram_used != '0) && (pipe_occ < CNT_W'(SKID_DEPTH));
        pipe_out     = rd_pipe[RD_LAT-1];
        skid_pop     = hdr_rd_valid && hdr_rd_ready;
        wr_ptr_nxt   = wr_ptr + PTR_W'(wr_accept);
        rd_ptr_nxt   = rd_ptr + PTR_W'(rd_issue);
        ram_used_nxt = wr_ptr_nxt - rd_ptr_nxt;
        inflight_nxt = inflight + LAT_CW'(rd_issue) - LAT_CW'(pipe_out);
        skid_cnt_nxt = skid_cnt + SKID_CW'(pipe_out) - SKID_CW'(skid_pop);
        count_nxt    = CNT_W'(ram_used_nxt) + CNT_W'(inflight_nxt) + CNT_W'(skid_cnt_nxt);
    end

    // Shift the in-flight read marker along the RAM latency
    always_comb begin
        rd_pipe_nxt    = '0;
        rd_pipe_nxt[0] = rd_issue;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            rd_pipe_nxt[i] = rd_pipe[i-1];
        end
    end

    // RAM write port is a same-cycle view of the accepted header
    assign ram_wr_en   = wr_accept;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = hdr_wr_data;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign hdr_rd_data = skid_mem[skid_rd];

    // Control state: pointers, pipe, skid indices and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_pipe      <= '0;
            inflight     <= '0;
            skid_wr      <= '0;
            skid_rd      <= '0;
            skid_cnt     <= '0;
            hdr_wr_ready <= 1'b0;
            hdr_rd_valid <= 1'b0;
            hdr_count    <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            rd_pipe      <= rd_pipe_nxt;
            inflight     <= inflight_nxt;
            skid_cnt     <= skid_cnt_nxt;
            hdr_wr_ready <= (ram_used_nxt < PTR_W'(DEPTH));
            hdr_rd_valid <= (skid_cnt_nxt != '0);
            hdr_count    <= count_nxt;
            if (pipe_out) begin
                skid_wr <= skid_inc(skid_wr);
            end
            if (skid_pop) begin
                skid_rd <= skid_inc(skid_rd);
            end
        end
    end

    // Skid storage captures RAM data as the matching read leaves the pipe
    always_ff @(posedge clk) begin
        if (pipe_out) begin
            skid_mem[skid_wr] <= ram_rd_data;
        end
    end

`ifdef IPSL_PCIE_RCVH_OVFL_CNT_EN
    // Saturating count of cycles where upstream offers a header we cannot take
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl_cnt <= '0;
        end else if (hdr_wr_valid && !hdr_wr_ready && (ovfl_cnt != 16'hFFFF)) begin
            ovfl_cnt <= ovfl_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ipsl_pcie_ext_rcvh_fifo_ctrl.sv
// Directed and randomized checks of the receive-header FIFO controller with a
// behavioural 2-cycle-latency RAM attached.
module tb_ipsl_pcie_ext_rcvh_fifo_ctrl;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 144;
    localparam int unsigned CW = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hdr_wr_valid;
    logic [DW-1:0] hdr_wr_data;
    logic          hdr_wr_ready;
    logic          hdr_rd_valid;
    logic [DW-1:0] hdr_rd_data;
    logic          hdr_rd_ready;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [CW-1:0] hdr_count;
`ifdef IPSL_PCIE_RCVH_OVFL_CNT_EN
    logic [15:0]   ovfl_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // scoreboard state, filled by the monitor
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] pop_q[$];
    int            acc_n = 0;
    int            pop_n = 0;

    always #5 clk = ~clk;

    ipsl_pcie_ext_rcvh_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hdr_wr_valid (hdr_wr_valid),
        .hdr_wr_data  (hdr_wr_data),
        .hdr_wr_ready (hdr_wr_ready),
        .hdr_rd_valid (hdr_rd_valid),
        .hdr_rd_data  (hdr_rd_data),
        .hdr_rd_ready (hdr_rd_ready),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
`ifdef IPSL_PCIE_RCVH_OVFL_CNT_EN
        .ovfl_cnt     (ovfl_cnt),
`endif
        .hdr_count    (hdr_count)
    );

    // behavioural SDP RAM: address registered, output registered
    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rd_s1;
    logic [DW-1:0] rd_s2;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        rd_s1 <= mem[ram_rd_addr];
        rd_s2 <= rd_s1;
    end
    assign ram_rd_data = rd_s2;

    // record every handshake mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_q.delete();
            pop_q.delete();
            acc_n = 0;
            pop_n = 0;
        end else begin
            if (hdr_wr_valid && hdr_wr_ready) begin
                acc_q.push_back(hdr_wr_data);
                acc_n++;
            end
            if (hdr_rd_valid && hdr_rd_ready) begin
                pop_q.push_back(hdr_rd_data);
                pop_n++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hdr_wr_valid = 1'b0; hdr_wr_data = '0; hdr_rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (hdr_wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%0h exp=0", hdr_wr_ready); end
        total++; if (hdr_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%0h exp=0", hdr_rd_valid); end
        total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0h exp=0", ram_wr_en); end
        total++; if (ram_rd_addr !== AW'(0)) begin bad++; $display("FAIL rst_rd_addr got=%0h exp=0", ram_rd_addr); end
        total++; if (hdr_count !== CW'(0)) begin bad++; $display("FAIL rst_count got=%0d exp=0", hdr_count); end
`ifdef IPSL_PCIE_RCVH_OVFL_CNT_EN
        total++; if (ovfl_cnt !== 16'd0) begin bad++; $display("FAIL rst_ovfl got=%0d exp=0", ovfl_cnt); end
`endif
        #3 rst_n = 1'b1;
        #2;
        total++; if (hdr_wr_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_early got=%0h exp=0", hdr_wr_ready); end
        next_cycle();
        total++; if (hdr_wr_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%0h exp=1", hdr_wr_ready); end
    endtask

    task automatic test_single();
        logic exp_v;
        hdr_wr_valid = 1'b1;
        hdr_wr_data  = DW'(144'hA5);
        @(negedge clk);
        total++; if (ram_wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got=%0h exp=1", ram_wr_en); end
        total++; if (ram_wr_addr !== AW'(0)) begin bad++; $display("FAIL single_wr_addr got=%0h exp=0", ram_wr_addr); end
        total++; if (ram_wr_data !== DW'(144'hA5)) begin bad++; $display("FAIL single_wr_data got=%0h exp=a5", ram_wr_data); end
        next_cycle();
        hdr_wr_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_v = (k >= 3);
            total++; if (hdr_rd_valid !== exp_v) begin bad++; $display("FAIL single_valid_k%0d got=%0h exp=%0h", k, hdr_rd_valid, exp_v); end
            total++; if (hdr_count !== CW'(1)) begin bad++; $display("FAIL single_count_k%0d got=%0d exp=1", k, hdr_count); end
            if (k >= 3) begin
                total++; if (hdr_rd_data !== DW'(144'hA5)) begin bad++; $display("FAIL single_rd_data_k%0d got=%0h exp=a5", k, hdr_rd_data); end
            end
            if (k < 5) next_cycle();
        end
        hdr_rd_ready = 1'b1;
        next_cycle();
        hdr_rd_ready = 1'b0;
        total++; if (hdr_rd_valid !== 1'b0) begin bad++; $display("FAIL single_after_pop_valid got=%0h exp=0", hdr_rd_valid); end
        total++; if (hdr_count !== CW'(0)) begin bad++; $display("FAIL single_after_pop_count got=%0d exp=0", hdr_count); end
        total++; if (pop_q.size() != 1) begin bad++; $display("FAIL single_pop_n got=%0d exp=1", pop_q.size()); end
        while (pop_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = pop_q.pop_front(); e = acc_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL single_data got=%0h exp=%0h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        int acc0, pop0, prev_pop, cyc, first_pop, last_pop, max_cnt;
        acc0 = acc_n; pop0 = pop_n; prev_pop = pop_n;
        cyc = 0; first_pop = -1; last_pop = -1; max_cnt = 0;
        hdr_rd_ready = 1'b1;
        while ((pop_n - pop0) < 100 && cyc < 300) begin
            hdr_wr_valid = ((acc_n - acc0) < 100);
            hdr_wr_data  = DW'(1000 + acc_n - acc0);
            next_cycle();
            cyc++;
            if (pop_n != prev_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                prev_pop = pop_n;
            end
            if (int'(hdr_count) > max_cnt) max_cnt = int'(hdr_count);
            total++; if (hdr_count !== CW'(acc_n - pop_n)) begin bad++; $display("FAIL b2b_count cyc%0d got=%0d exp=%0d", cyc, hdr_count, acc_n - pop_n); end
        end
        hdr_wr_valid = 1'b0;
        hdr_rd_ready = 1'b0;
        total++; if ((pop_n - pop0) != 100) begin bad++; $display("FAIL b2b_timeout popped=%0d exp=100", pop_n - pop0); end
        total++; if (max_cnt > 4) begin bad++; $display("FAIL b2b_max_count got=%0d exp<=4", max_cnt); end
        total++; if ((last_pop - first_pop) != 99) begin bad++; $display("FAIL b2b_bubbles span=%0d exp=99", last_pop - first_pop); end
        while (pop_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = pop_q.pop_front(); e = acc_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL b2b_data got=%0h exp=%0h", g, e); end
        end
    endtask

    task automatic test_fill();
        int acc0;
        acc0 = acc_n;
        hdr_rd_ready = 1'b0;
        for (int c = 0; c < 600; c++) begin
            hdr_wr_valid = 1'b1;
            hdr_wr_data  = DW'(2000 + c);
            next_cycle();
            total++; if (hdr_count !== CW'(acc_n - pop_n)) begin bad++; $display("FAIL fill_count c%0d got=%0d exp=%0d", c, hdr_count, acc_n - pop_n); end
        end
        hdr_wr_valid = 1'b0;
        total++; if ((acc_n - acc0) != 516) begin bad++; $display("FAIL fill_accepted got=%0d exp=516", acc_n - acc0); end
        total++; if (hdr_wr_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0h exp=0", hdr_wr_ready); end
        total++; if (hdr_count !== CW'(516)) begin bad++; $display("FAIL fill_count_final got=%0d exp=516", hdr_count); end
        total++; if (hdr_rd_valid !== 1'b1) begin bad++; $display("FAIL fill_rd_valid got=%0h exp=1", hdr_rd_valid); end
`ifdef IPSL_PCIE_RCVH_OVFL_CNT_EN
        total++; if (ovfl_cnt !== 16'd84) begin bad++; $display("FAIL fill_ovfl got=%0d exp=84", ovfl_cnt); end
`endif
    endtask

    task automatic test_wrap();
        int w, n;
        logic [AW-1:0] exp_addr;
        hdr_rd_ready = 1'b1;
        next_cycle();
        hdr_rd_ready = 1'b0;
        w = 0;
        while (!hdr_wr_ready && w < 2) begin
            next_cycle();
            w++;
        end
        total++; if (hdr_wr_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%0h exp=1 after %0d clks", hdr_wr_ready, w); end
        exp_addr = AW'(acc_n % 512);
        hdr_wr_valid = 1'b1;
        hdr_wr_data  = DW'(3000);
        @(negedge clk);
        total++; if (ram_wr_en !== 1'b1) begin bad++; $display("FAIL wrap_wr_en got=%0h exp=1", ram_wr_en); end
        total++; if (ram_wr_addr !== exp_addr) begin bad++; $display("FAIL wrap_wr_addr got=%0h exp=%0h", ram_wr_addr, exp_addr); end
        next_cycle();
        hdr_wr_valid = 1'b0;
        total++; if (hdr_count !== CW'(516)) begin bad++; $display("FAIL wrap_count got=%0d exp=516", hdr_count); end
        hdr_rd_ready = 1'b1;
        n = 0;
        while (pop_n != acc_n && n < 2000) begin
            next_cycle();
            n++;
        end
        hdr_rd_ready = 1'b0;
        total++; if (pop_n != acc_n) begin bad++; $display("FAIL wrap_drain_timeout popped=%0d exp=%0d", pop_n, acc_n); end
        total++; if (hdr_count !== CW'(0)) begin bad++; $display("FAIL wrap_count_empty got=%0d exp=0", hdr_count); end
        total++; if (pop_q.size() != 517) begin bad++; $display("FAIL wrap_pop_n got=%0d exp=517", pop_q.size()); end
        while (pop_q.size() > 0 && acc_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = pop_q.pop_front(); e = acc_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL wrap_data got=%0h exp=%0h", g, e); end
        end
    endtask

    task automatic test_random();
        int acc0, cyc, n;
        acc0 = acc_n;
        cyc  = 0;
        while ((acc_n - acc0) < 10000 && cyc < 60000) begin
            hdr_wr_valid = ($urandom_range(3) != 0);
            hdr_wr_data  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
            hdr_rd_ready = ($urandom_range(1) != 0);
            next_cycle();
            cyc++;
            total++; if (hdr_count !== CW'(acc_n - pop_n)) begin bad++; $display("FAIL rand_count cyc%0d got=%0d exp=%0d", cyc, hdr_count, acc_n - pop_n); end
        end
        total++; if ((acc_n - acc0) < 10000) begin bad++; $display("FAIL rand_timeout accepted=%0d exp=10000", acc_n - acc0); end
        hdr_wr_valid = 1'b0;
        hdr_rd_ready = 1'b1;
        n = 0;
        while (pop_n != acc_n && n < 2000) begin
            next_cycle();
            n++;
            total++; if (hdr_count !== CW'(acc_n - pop_n)) begin bad++; $display("FAIL rand_drain_count got=%0d exp=%0d", hdr_count, acc_n - pop_n); end
        end
        hdr_rd_ready = 1'b0;
        total++; if (pop_n != acc_n) begin bad++; $display("FAIL rand_drain_timeout popped=%0d exp=%0d", pop_n, acc_n); end
        while (pop_q.size() > 0 && acc_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = pop_q.pop_front(); e = acc_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL rand_data got=%0h exp=%0h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic exp_v;
        hdr_rd_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            hdr_wr_valid = 1'b1;
            hdr_wr_data  = DW'(4000 + c);
            next_cycle();
        end
        total++; if (hdr_count !== CW'(50)) begin bad++; $display("FAIL mid_count_held got=%0d exp=50", hdr_count); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (hdr_wr_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0h exp=0", hdr_wr_ready); end
        total++; if (hdr_rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_valid got=%0h exp=0", hdr_rd_valid); end
        total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr_en got=%0h exp=0", ram_wr_en); end
        total++; if (hdr_count !== CW'(0)) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", hdr_count); end
        total++; if (ram_rd_addr !== AW'(0)) begin bad++; $display("FAIL mid_rst_rd_addr got=%0h exp=0", ram_rd_addr); end
        total++; if (ram_wr_addr !== AW'(0)) begin bad++; $display("FAIL mid_rst_wr_addr got=%0h exp=0", ram_wr_addr); end
        hdr_wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            total++; if (hdr_rd_valid !== 1'b0) begin bad++; $display("FAIL mid_post_valid k%0d got=%0h exp=0", k, hdr_rd_valid); end
            total++; if (hdr_count !== CW'(0)) begin bad++; $display("FAIL mid_post_count k%0d got=%0d exp=0", k, hdr_count); end
        end
        hdr_wr_valid = 1'b1;
        hdr_wr_data  = DW'(5000);
        next_cycle();
        hdr_wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_v = (k == 3);
            total++; if (hdr_rd_valid !== exp_v) begin bad++; $display("FAIL mid_new_valid k%0d got=%0h exp=%0h", k, hdr_rd_valid, exp_v); end
            if (k < 3) next_cycle();
        end
        total++; if (hdr_rd_data !== DW'(5000)) begin bad++; $display("FAIL mid_new_data got=%0h exp=%0h", hdr_rd_data, DW'(5000)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
